// File: rtl/tt6581_pkg.sv
// Shared types and widths for the voice scheduler: FSM state encoding,
// mix/product widths and the product sign-extension helper.
package tt6581_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } vs_state_t;

   localparam int MIX_W      = 20;
   localparam int PROD_SIG_W = 18;

   // Three full-scale 18-bit products still fit in MIX_W, so no saturation.
   function automatic logic signed [MIX_W-1:0] sext_prod(input logic [PROD_SIG_W-1:0] p);
      return {{(MIX_W-PROD_SIG_W){p[PROD_SIG_W-1]}}, p};
   endfunction

endpackage

// File: rtl/voice_sched.sv
// Per-frame voice sequencer: starts the envelope/mult once per voice, sums the products.
// Optional VOICE_SCHED_MUTE_EN adds mute_i; a muted voice costs one cycle and adds 0.
//
// state | meaning
// IDLE  | waiting for tick_i; accumulator and voice counter cleared on accept
// START | one-cycle env_start_o for voice cnt (muted voice: advance, add 0)
// WAIT  | waiting for a rising edge on env_ready_i, bounded by TIMEOUT_CYC
// DONE  | mix_o just loaded, mix_valid_o high; back to IDLE
module voice_sched
   import tt6581_pkg::*;
#(
   parameter int NUM_VOICES  = 3,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    tick_i,
   output logic                    env_start_o,
   output logic [1:0]              env_voice_idx_o,
   input  logic                    env_ready_i,
`ifdef VOICE_SCHED_MUTE_EN
   input  logic [NUM_VOICES-1:0]   mute_i,
`endif
   input  logic [39:0]             prod_i,
   output logic signed [MIX_W-1:0] mix_o,
   output logic                    mix_valid_o,
   output logic                    busy_o,
   output logic                    overrun_o,
   output logic                    timeout_o
);

   localparam int               TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [1:0]       LAST_IDX = 2'(NUM_VOICES - 1);

   vs_state_t               state;
   vs_state_t               state_nxt;
   logic [1:0]              cnt;
   logic signed [MIX_W-1:0] acc;
   logic signed [MIX_W-1:0] acc_nxt;
   logic signed [MIX_W-1:0] addend;
   logic [TMR_W-1:0]        tmr;
   logic                    rdy_q;
   logic                    rdy_rise;
   logic                    frame_go;
   logic                    advance;
   logic                    to_hit;
   logic                    last_voice;
   logic                    voice_muted;
   logic                    unused_prod_hi;

`ifdef VOICE_SCHED_MUTE_EN
   assign voice_muted = mute_i[cnt];
`else
   assign voice_muted = 1'b0;
`endif

   // Only a fresh rising edge completes a voice; a level held from before START is ignored.
   assign rdy_rise        = env_ready_i & ~rdy_q;
   assign last_voice      = (cnt == LAST_IDX);
   assign acc_nxt         = acc + addend;
   assign busy_o          = (state != IDLE);
   assign env_voice_idx_o = cnt;
   assign unused_prod_hi  = ^prod_i[39:PROD_SIG_W];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      env_start_o = 1'b0;
      frame_go    = 1'b0;
      advance     = 1'b0;
      to_hit      = 1'b0;
      addend      = '0;
      case (state)
         IDLE: begin
            if (tick_i) begin
               frame_go  = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (voice_muted) begin
               advance = 1'b1;
            end else begin
               env_start_o = 1'b1;
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            if (rdy_rise) begin
               advance = 1'b1;
               addend  = sext_prod(prod_i[PROD_SIG_W-1:0]);
            end else if (tmr == '0) begin
               advance = 1'b1;
               to_hit  = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (advance) state_nxt = last_voice ? DONE : START;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt         <= '0;
         acc         <= '0;
         tmr         <= '0;
         rdy_q       <= 1'b0;
         mix_o       <= '0;
         mix_valid_o <= 1'b0;
         overrun_o   <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         rdy_q       <= env_ready_i;
         mix_valid_o <= 1'b0;
         if (tick_i && (state != IDLE)) overrun_o <= 1'b1;
         if (to_hit)                    timeout_o <= 1'b1;
         // Down-counter: terminal count 0 is reached on the TIMEOUT_CYC-th WAIT cycle.
         if (env_start_o)         tmr <= TMR_LOAD;
         else if (state == WAIT)  tmr <= tmr - 1'b1;
         if (frame_go) begin
            acc <= '0;
            cnt <= '0;
         end else if (advance) begin
            acc <= acc_nxt;
            if (last_voice) begin
               mix_o       <= acc_nxt;
               mix_valid_o <= 1'b1;
            end else begin
               cnt <= cnt + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_voice_sched.sv
// Bench for voice_sched: table of frame vectors, hand-written overrun/reset sequences,
// and random frames checked against a per-voice cost/sum model.
module tb_voice_sched;

   localparam int NV     = 3;
   localparam int TO_CYC = 255;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               tick_i;
   logic               env_start_o;
   logic [1:0]         env_voice_idx_o;
   logic               env_ready_i;
   logic [39:0]        prod_i;
   logic signed [19:0] mix_o;
   logic               mix_valid_o;
   logic               busy_o;
   logic               overrun_o;
   logic               timeout_o;
`ifdef VOICE_SCHED_MUTE_EN
   logic [NV-1:0]      mute_i;
`endif

   always #5 clk_i = ~clk_i;

   voice_sched #(.NUM_VOICES(NV), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .tick_i          (tick_i),
      .env_start_o     (env_start_o),
      .env_voice_idx_o (env_voice_idx_o),
      .env_ready_i     (env_ready_i),
`ifdef VOICE_SCHED_MUTE_EN
      .mute_i          (mute_i),
`endif
      .prod_i          (prod_i),
      .mix_o           (mix_o),
      .mix_valid_o     (mix_valid_o),
      .busy_o          (busy_o),
      .overrun_o       (overrun_o),
      .timeout_o       (timeout_o)
   );

   // lat: WAIT cycles with ready low before it rises; -1 = never rises.
   typedef struct {
      string     name;
      int        lat  [NV];
      int        prod [NV];
      bit        hold;
      bit [NV-1:0] mute;
      int        exp_mix;
      int        exp_lat;
      bit        exp_to;
   } vec_t;

   vec_t tab[$];
   vec_t cur;
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   mv_total = 0;
   int   starts[$];

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (env_start_o === 1'b1) starts.push_back(int'(env_voice_idx_o));
      if (mix_valid_o === 1'b1) mv_total <= mv_total + 1;
   end

   // Envelope/mult stand-in: reacts to each start using the current vector.
   always begin : env_model
      int v;
      @(negedge clk_i);
      if (env_start_o === 1'b1) begin
         v = int'(env_voice_idx_o);
         prod_i = {22'($urandom), 18'(cur.prod[v])};
         if (cur.lat[v] < 0) begin
            env_ready_i = cur.hold;
         end else begin
            env_ready_i = 1'b0;
            repeat (cur.lat[v] + 1) @(posedge clk_i);
            #1 env_ready_i = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Frame cost per voice: muted 1, timed out 1+TO_CYC, completed START+lat+completion cycle.
   function automatic void model(input vec_t v, output int mix, output int lat, output bit to);
      mix = 0;
      lat = 1;
      to  = 1'b0;
      for (int i = 0; i < NV; i++) begin
         if (v.mute[i]) begin
            lat += 1;
         end else if (v.lat[i] < 0 || v.lat[i] >= TO_CYC) begin
            lat += 1 + TO_CYC;
            to   = 1'b1;
         end else begin
            mix += v.prod[i];
            lat += 2 + v.lat[i];
         end
      end
   endfunction

   task automatic add_vec(input string n, input int l0, input int l1, input int l2,
                          input int p0, input int p1, input int p2, input bit h,
                          input bit [NV-1:0] m, input int em, input int el, input bit et);
      vec_t v;
      v.name = n;
      v.lat[0] = l0;  v.lat[1] = l1;  v.lat[2] = l2;
      v.prod[0] = p0; v.prod[1] = p1; v.prod[2] = p2;
      v.hold = h; v.mute = m; v.exp_mix = em; v.exp_lat = el; v.exp_to = et;
      tab.push_back(v);
   endtask

   task automatic check_zero(input string p);
      chk({p, " env_start"}, env_start_o, 0);
      chk({p, " voice_idx"}, env_voice_idx_o, 0);
      chk({p, " mix"}, mix_o, 0);
      chk({p, " mix_valid"}, mix_valid_o, 0);
      chk({p, " busy"}, busy_o, 0);
      chk({p, " overrun"}, overrun_o, 0);
      chk({p, " timeout"}, timeout_o, 0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      tick_i = 1'b0;
      env_ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic run_frame(input vec_t v, input bit exp_to, input bit exp_ovr, input int inj);
      int t0, tv, base_mv, n;
      logic signed [19:0] mv;
      bit got;
      int exp_starts[$];
      cur = v;
`ifdef VOICE_SCHED_MUTE_EN
      mute_i = v.mute;
`endif
      starts.delete();
      @(posedge clk_i);
      #1;
      base_mv = mv_total;
      tick_i  = 1'b1;
      t0      = cyc;
      if (inj > 0) begin
         fork
            begin
               repeat (inj) @(posedge clk_i);
               #1 tick_i = 1'b1;
               @(posedge clk_i);
               #1 tick_i = 1'b0;
            end
         join_none
      end
      @(posedge clk_i);
      #1 tick_i = 1'b0;
      got = 1'b0;
      n   = 0;
      tv  = 0;
      mv  = '0;
      while (!got && n < 2000) begin
         @(negedge clk_i);
         n++;
         if (mix_valid_o === 1'b1) begin
            got = 1'b1;
            tv  = cyc;
            mv  = mix_o;
         end
      end
      chk({v.name, " mix_valid seen"}, got, 1);
      if (got) begin
         chk({v.name, " latency"}, tv - t0, v.exp_lat);
         chk({v.name, " mix"}, mv, v.exp_mix);
      end
      @(negedge clk_i);
      #1;
      chk({v.name, " mix_valid one cycle"}, mix_valid_o, 0);
      chk({v.name, " mix held"}, mix_o, v.exp_mix);
      chk({v.name, " busy after"}, busy_o, 0);
      chk({v.name, " timeout flag"}, timeout_o, exp_to);
      chk({v.name, " overrun flag"}, overrun_o, exp_ovr);
      chk({v.name, " mix_valid count"}, mv_total - base_mv, 1);
      for (int i = 0; i < NV; i++) if (!v.mute[i]) exp_starts.push_back(i);
      chk({v.name, " start count"}, starts.size(), exp_starts.size());
      for (int i = 0; i < exp_starts.size() && i < starts.size(); i++)
         chk($sformatf("%s start idx %0d", v.name, i), starts[i], exp_starts[i]);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : main
      int t0, base, n;
      bit to_acc;
      vec_t v;
      int em, el;
      bit et;

      rst_i = 1'b1;
      tick_i = 1'b0;
      env_ready_i = 1'b0;
      prod_i = '0;
`ifdef VOICE_SCHED_MUTE_EN
      mute_i = '0;
`endif
      cur.lat = '{5, 5, 5};
      cur.prod = '{0, 0, 0};
      cur.hold = 1'b0;
      cur.mute = '0;
      repeat (3) @(negedge clk_i);
      check_zero("reset");
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("idle without tick busy", busy_o, 0);
      chk("idle without tick start", env_start_o, 0);

      add_vec("basic",   5,  5,   5,     100,     -30,       7, 0, 3'b000,     77,  22, 0);
      add_vec("negfull", 0,  3,   1, -131072, -131072, -131072, 0, 3'b000, -393216, 11, 0);
      add_vec("posfull", 2,  2,   2,  131071,  131071,  131071, 0, 3'b000,  393213, 13, 0);
      add_vec("lat254",  254, 0,  0,       1,       2,       3, 0, 3'b000,      6, 261, 0);
      add_vec("hold_to", 5, -1,   5,     100,     999,       7, 1, 3'b000,    107, 271, 1);
      add_vec("late255", 0,  0, 255,      10,      20,      30, 0, 3'b000,     30, 261, 1);
`ifdef VOICE_SCHED_MUTE_EN
      add_vec("mute010", 5,  5,   5,     100,     -30,       7, 0, 3'b010,    107,  16, 0);
`endif
      for (int i = 0; i < tab.size(); i++) begin
         do_reset();
         run_frame(tab[i], tab[i].exp_to, 1'b0, 0);
      end

      // Tick mid-frame: dropped, flagged, result unchanged, no second frame.
      do_reset();
      run_frame(tab[0], 1'b0, 1'b1, 10);
      base = mv_total;
      repeat (40) @(negedge clk_i);
      #1;
      chk("ovr no second mix_valid", mv_total - base, 0);
      chk("ovr no extra starts", starts.size(), 3);
      chk("ovr sticky", overrun_o, 1);

      // Tick in the DONE cycle counts as overrun.
      do_reset();
      cur = tab[0];
      starts.delete();
      @(posedge clk_i);
      #1 tick_i = 1'b1;
      t0 = cyc;
      @(posedge clk_i);
      #1 tick_i = 1'b0;
      repeat (21) @(posedge clk_i);
      #1;
      chk("done cycle reached", cyc - t0, 22);
      chk("done cycle mix_valid", mix_valid_o, 1);
      chk("done cycle overrun before", overrun_o, 0);
      tick_i = 1'b1;
      @(posedge clk_i);
      #1 tick_i = 1'b0;
      chk("done-exit tick overrun", overrun_o, 1);
      chk("done-exit tick not accepted", busy_o, 0);
      repeat (10) @(negedge clk_i);
      chk("done-exit no new frame", starts.size(), 3);
      chk("done-exit mix", mix_o, 77);

      // Reset during WAIT of voice 1 abandons the frame.
      starts.delete();
      base = mv_total;
      @(posedge clk_i);
      #1 tick_i = 1'b1;
      @(posedge clk_i);
      #1 tick_i = 1'b0;
      n = 0;
      while (starts.size() < 2 && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("rst reached voice 1", starts.size(), 2);
      repeat (2) @(negedge clk_i);
      chk("rst busy before", busy_o, 1);
      #2 rst_i = 1'b1;
      #1 check_zero("reset mid-frame");
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (60) @(negedge clk_i);
      #1;
      chk("rst no mix_valid", mv_total - base, 0);
      chk("rst no restart", starts.size(), 2);
      chk("rst idle", busy_o, 0);

      // Random frames against the model; timeout flag accumulates since reset.
      do_reset();
      to_acc = 1'b0;
      for (int k = 0; k < 25; k++) begin
         v.name = $sformatf("rnd%0d", k);
         v.hold = 1'b0;
         v.mute = '0;
         for (int i = 0; i < NV; i++) begin
            v.lat[i]  = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 9));
            v.prod[i] = int'($urandom_range(0, 262143)) - 131072;
`ifdef VOICE_SCHED_MUTE_EN
            v.mute[i] = ($urandom_range(0, 3) == 0);
`endif
         end
         model(v, em, el, et);
         v.exp_mix = em;
         v.exp_lat = el;
         v.exp_to  = et;
         to_acc    = to_acc | et;
         run_frame(v, to_acc, 1'b0, 0);
         repeat ($urandom_range(0, 3)) @(posedge clk_i);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
